// File: rtl/cpu.sv
// Single-cycle RV64 core: one instruction fetched, executed and retired per enabled clock.
// Instruction and data memories double as externally loadable/readable RAMs.

module cpu_regfile (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [63:0] wd,
  output logic [63:0] rd1,
  output logic [63:0] rd2
);
  logic [63:0] reg_array [0:31];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < 32; i++) reg_array[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      reg_array[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 64'd0 : reg_array[ra1];
  assign rd2 = (ra2 == 5'd0) ? 64'd0 : reg_array[ra2];
endmodule

module cpu (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        enable,
  input  logic [63:0] addr_ext,
  input  logic        wen_ext,
  input  logic        ren_ext,
  input  logic [31:0] wdata_ext,
  output logic [31:0] rdata_ext,
  input  logic [63:0] addr_ext_2,
  input  logic        wen_ext_2,
  input  logic        ren_ext_2,
  input  logic [63:0] wdata_ext_2,
  output logic [63:0] rdata_ext_2
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STOP   = 7'b1111110;

  logic [31:0] imem [0:511];
  logic [63:0] dmem [0:1023];

  logic [63:0] pc_q, pc_d;
  logic [31:0] instruction;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [63:0] rs1_val, rs2_val;
  logic [63:0] imm_i, imm_s, imm_b, imm_j;
  logic [63:0] ls_addr, rd_wdata;
  logic [9:0]  ls_idx;
  logic        rd_we, dmem_we;
  logic        unused_ok;

  assign instruction = imem[pc_q[10:2]];
  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  assign ls_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign ls_idx  = ls_addr[11:2];

  cpu_regfile register_file (
    .clk    (clk),
    .arst_n (arst_n),
    .we     (rd_we),
    .ra1    (rs1),
    .ra2    (rs2),
    .wa     (rd),
    .wd     (rd_wdata),
    .rd1    (rs1_val),
    .rd2    (rs2_val)
  );

  always_comb begin
    pc_d     = pc_q + 64'd4;
    rd_we    = 1'b0;
    rd_wdata = '0;
    dmem_we  = 1'b0;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
          rd_we = 1'b1; rd_wdata = rs1_val + rs2_val;
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          rd_we = 1'b1; rd_wdata = rs1_val - rs2_val;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
          rd_we = 1'b1; rd_wdata = rs1_val & rs2_val;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
          rd_we = 1'b1; rd_wdata = rs1_val | rs2_val;
        end else if (funct7 == 7'b0000000 && funct3 == 3'b001) begin
          rd_we = 1'b1; rd_wdata = rs1_val << rs2_val[5:0];
        end else if (funct7 == 7'b0000001 && funct3 == 3'b000) begin
          rd_we = 1'b1; rd_wdata = rs1_val * rs2_val;
        end
      end
      OP_IMM: if (funct3 == 3'b000) begin
        rd_we = 1'b1; rd_wdata = rs1_val + imm_i;
      end
      OP_LOAD: if (funct3 == 3'b011) begin
        rd_we = 1'b1; rd_wdata = dmem[ls_idx];
      end
      OP_STORE:  if (funct3 == 3'b011) dmem_we = 1'b1;
      OP_BRANCH: if (funct3 == 3'b000 && rs1_val == rs2_val) pc_d = pc_q + imm_b;
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + 64'd4;
        pc_d     = pc_q + imm_j;
      end
      OP_STOP: pc_d = pc_q;
      default: ;
    endcase
    // A frozen core, or one held in reset, must leave no architectural trace.
    if (!enable || !arst_n) begin
      pc_d    = pc_q;
      rd_we   = 1'b0;
      dmem_we = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) pc_q <= '0;
    else         pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
  end

  // The external write is issued last so it wins when both hit the same entry.
  always_ff @(posedge clk) begin
    if (dmem_we)   dmem[ls_idx] <= rs2_val;
    if (wen_ext_2) dmem[addr_ext_2[11:2]] <= wdata_ext_2;
  end

  assign rdata_ext   = ren_ext   ? imem[addr_ext[10:2]]   : 32'd0;
  assign rdata_ext_2 = ren_ext_2 ? dmem[addr_ext_2[11:2]] : 64'd0;

  assign unused_ok = ^{addr_ext[63:11], addr_ext[1:0], addr_ext_2[63:12], addr_ext_2[1:0],
                       ls_addr[63:12], ls_addr[1:0]};
endmodule

// File: tb/tb_cpu.sv
// Directed bench for the single-cycle RV64 core: memory load/readback, programs, STOP, enable, reset.
module tb_cpu;
  logic        clk = 1'b0;
  logic        arst_n;
  logic        enable;
  logic [63:0] addr_ext;
  logic        wen_ext, ren_ext;
  logic [31:0] wdata_ext, rdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2, ren_ext_2;
  logic [63:0] wdata_ext_2, rdata_ext_2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] exp_q[$];
  logic [4:0]  idx_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] imem_m [0:511];
  logic [63:0] dmem_m [0:1023];

  localparam logic [31:0] STOP = 32'h0000_007E;

  always #5 clk = ~clk;

  cpu dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .enable      (enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .rdata_ext   (rdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic imem_write(input int idx, input logic [31:0] w);
    logic [8:0] i9;
    i9 = idx[8:0];
    @(negedge clk);
    addr_ext  = {32'($urandom), 21'($urandom), i9, 2'b00};
    wdata_ext = w;
    wen_ext   = 1'b1;
    @(negedge clk);
    wen_ext   = 1'b0;
    imem_m[i9] = w;
  endtask

  task automatic dmem_write(input int idx, input logic [63:0] d);
    logic [9:0] i10;
    i10 = idx[9:0];
    @(negedge clk);
    addr_ext_2  = {32'($urandom), 20'($urandom), i10, 2'b00};
    wdata_ext_2 = d;
    wen_ext_2   = 1'b1;
    @(negedge clk);
    wen_ext_2   = 1'b0;
    dmem_m[i10] = d;
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog_q.size(); i++) imem_write(i, prog_q[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic expect_reg(input logic [4:0] idx, input logic [63:0] val);
    idx_q.push_back(idx);
    exp_q.push_back(val);
  endtask

  task automatic check_regs(input string tag);
    logic [4:0]  idx;
    logic [63:0] val;
    while (exp_q.size() > 0) begin
      idx = idx_q.pop_front();
      val = exp_q.pop_front();
      check($sformatf("%s_x%0d", tag, idx), dut.register_file.reg_array[idx], val);
    end
  endtask

  task automatic run_until_stop(input int pause_at, input int pause_len, output int cycles);
    bit stopped;
    stopped = 1'b0;
    cycles  = 0;
    @(negedge clk);
    enable = 1'b1;
    while (cycles < 200 && !stopped) begin
      if (cycles == pause_at) enable = 1'b0;
      if (cycles == pause_at + pause_len) enable = 1'b1;
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (dut.instruction === STOP) stopped = 1'b1;
    end
    check("stop_reached", 64'(stopped), 64'd1);
  endtask

  task automatic expect_prog1();
    expect_reg(5'd0, 64'd0);
    expect_reg(5'd1, 64'd40);
    expect_reg(5'd8, 64'd7);
    expect_reg(5'd9, 64'd9);
    expect_reg(5'd18, 64'd9);
    expect_reg(5'd19, 64'd16);
    expect_reg(5'd20, 64'd25);
    expect_reg(5'd21, 64'd1152);
  endtask

  initial begin
    int cycles;
    logic [63:0] obs;
    arst_n = 1'b0; enable = 1'b0;
    addr_ext = '0; wen_ext = 1'b0; ren_ext = 1'b0; wdata_ext = '0;
    addr_ext_2 = '0; wen_ext_2 = 1'b0; ren_ext_2 = 1'b0; wdata_ext_2 = '0;
    #12;
    check("reset_x8", dut.register_file.reg_array[8], 64'd0);
    check("reset_x31", dut.register_file.reg_array[31], 64'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Full-memory load and readback through the external ports, random upper address bits.
    for (int i = 0; i < 512; i++) imem_write(i, $urandom);
    for (int i = 0; i < 1024; i++) dmem_write(i, {$urandom, $urandom});
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      addr_ext = {32'($urandom), 21'($urandom), 9'(i), 2'b00};
      ren_ext  = 1'b1;
      exp_q.push_back({32'd0, imem_m[i]});
      #2;
      check($sformatf("imem_rd_%0d", i), {32'd0, rdata_ext}, exp_q.pop_front());
    end
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      addr_ext_2 = {32'($urandom), 20'($urandom), 10'(i), 2'b00};
      ren_ext_2  = 1'b1;
      exp_q.push_back(dmem_m[i]);
      #2;
      check($sformatf("dmem_rd_%0d", i), rdata_ext_2, exp_q.pop_front());
    end
    @(negedge clk);
    ren_ext = 1'b0; ren_ext_2 = 1'b0;
    #2;
    check("imem_ren_low", {32'd0, rdata_ext}, 64'd0);
    check("dmem_ren_low", rdata_ext_2, 64'd0);

    // Basic program with SD/LD, taken BEQ, SLL and JAL.
    prog_q = {};
    prog_q.push_back(i_type(12'd7, 5'd0, 3'b000, 5'd8, 7'b0010011));
    prog_q.push_back(i_type(12'd9, 5'd0, 3'b000, 5'd9, 7'b0010011));
    prog_q.push_back(s_type(12'd16, 5'd9, 5'd0));
    prog_q.push_back(i_type(12'd16, 5'd0, 3'b011, 5'd18, 7'b0000011));
    prog_q.push_back(r_type(7'd0, 5'd9, 5'd8, 3'b000, 5'd19));
    prog_q.push_back(r_type(7'd0, 5'd9, 5'd19, 3'b000, 5'd20));
    prog_q.push_back(b_type(13'd8, 5'd8, 5'd8));
    prog_q.push_back(i_type(12'd99, 5'd0, 3'b000, 5'd20, 7'b0010011));
    prog_q.push_back(r_type(7'd0, 5'd8, 5'd9, 3'b001, 5'd21));
    prog_q.push_back(j_type(21'd8, 5'd1));
    prog_q.push_back(i_type(12'd1, 5'd0, 3'b000, 5'd21, 7'b0010011));
    prog_q.push_back(STOP);
    load_prog();
    pulse_reset();
    expect_prog1();
    run_until_stop(-1, 0, cycles);
    check("prog1_cycles", 64'(cycles), 64'd9);
    check_regs("prog1");

    repeat (10) @(posedge clk);
    @(negedge clk);
    check("stop_hold_pc", {32'd0, dut.instruction}, {32'd0, STOP});
    expect_prog1();
    check_regs("stop_hold");
    enable = 1'b0;

    addr_ext_2 = 64'd16; ren_ext_2 = 1'b1;
    #2;
    check("sd_result", rdata_ext_2, 64'd9);
    addr_ext_2 = 64'h0000_0000_0000_1010;
    #2;
    obs = rdata_ext_2;
    check("sd_alias", obs, 64'd9);
    ren_ext_2 = 1'b0;

    // Same program with enable deasserted for 5 cycles mid-run.
    pulse_reset();
    expect_prog1();
    run_until_stop(4, 5, cycles);
    check("pause_cycles", 64'(cycles), 64'd14);
    check_regs("pause");
    enable = 1'b0;

    // MUL, x0 write, negative immediate, SUB/AND/OR, unsupported opcode.
    prog_q = {};
    prog_q.push_back(i_type(12'd10, 5'd0, 3'b000, 5'd5, 7'b0010011));
    prog_q.push_back(i_type(12'd19, 5'd0, 3'b000, 5'd6, 7'b0010011));
    prog_q.push_back(r_type(7'b0000001, 5'd6, 5'd5, 3'b000, 5'd9));
    prog_q.push_back(r_type(7'b0000001, 5'd6, 5'd5, 3'b000, 5'd23));
    prog_q.push_back(i_type(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));
    prog_q.push_back(i_type(12'hFFD, 5'd0, 3'b000, 5'd7, 7'b0010011));
    prog_q.push_back(r_type(7'b0100000, 5'd6, 5'd5, 3'b000, 5'd10));
    prog_q.push_back(r_type(7'd0, 5'd6, 5'd5, 3'b111, 5'd11));
    prog_q.push_back(r_type(7'd0, 5'd6, 5'd5, 3'b110, 5'd12));
    prog_q.push_back(32'h0000_0F8B);
    prog_q.push_back(STOP);
    load_prog();
    pulse_reset();
    expect_reg(5'd9, 64'h0000_0000_0000_00BE);
    expect_reg(5'd23, 64'h0000_0000_0000_00BE);
    expect_reg(5'd0, 64'd0);
    expect_reg(5'd7, 64'hFFFF_FFFF_FFFF_FFFD);
    expect_reg(5'd10, 64'hFFFF_FFFF_FFFF_FFF7);
    expect_reg(5'd11, 64'd2);
    expect_reg(5'd12, 64'd27);
    expect_reg(5'd31, 64'd0);
    run_until_stop(-1, 0, cycles);
    check("prog2_cycles", 64'(cycles), 64'd10);
    check_regs("prog2");
    enable = 1'b0;

    // Reset asserted mid-program takes effect without waiting for a clock edge.
    pulse_reset();
    @(negedge clk);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_reset_x5", dut.register_file.reg_array[5], 64'd10);
    arst_n = 1'b0;
    #1;
    check("async_reset_pc", {32'd0, dut.instruction}, {32'd0, prog_q[0]});
    check("async_reset_x5", dut.register_file.reg_array[5], 64'd0);
    check("async_reset_x6", dut.register_file.reg_array[6], 64'd0);
    @(posedge clk);
    #2;
    check("held_reset_x5", dut.register_file.reg_array[5], 64'd0);
    check("held_reset_pc", {32'd0, dut.instruction}, {32'd0, prog_q[0]});
    enable = 1'b0;
    arst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 arst_n  input  1  asynchronous, active-low reset.
REQ-003 enable  input  1  1 = core executes; 0 = core frozen, memories owned by external ports.
REQ-004 addr_ext  input  64  instruction-memory external byte address; word index = addr_ext[10:2].
REQ-005 wen_ext  input  1  external instruction-memory write strobe.
REQ-006 ren_ext  input  1  external instruction-memory read strobe.
REQ-007 wdata_ext  input  32  external instruction write data.
REQ-008 rdata_ext  output  32  external instruction read data.
REQ-009 addr_ext_2  input  64  data-memory external address; entry index = addr_ext_2[11:2].
REQ-010 wen_ext_2  input  1  external data-memory write strobe.
REQ-011 ren_ext_2  input  1  external data-memory read strobe.
REQ-012 wdata_ext_2  input  64  external data write data.
REQ-013 rdata_ext_2  output  64  external data read data.

Function
REQ-014 Single-cycle RV64 core: one instruction fetched, executed and retired per enabled clock; 64-bit datapath.
REQ-015 Instruction memory: 512 x 32 bit. Data memory: 1024 x 64 bit. Both written synchronously and read combinationally.
REQ-016 Data-memory entry for both core and external accesses = address[11:2]; higher address bits ignored; indices wrap modulo memory size.
REQ-017 External write: when wen_ext (wen_ext_2) = 1 at a rising clk edge, the addressed memory entry takes wdata_ext (wdata_ext_2); external writes have priority over core stores in the same cycle.
REQ-018 rdata_ext / rdata_ext_2 = addressed entry when the matching ren is 1, else 0.
REQ-019 Register file: instance named register_file, array reg_array[0:31] of 64-bit registers; 2 combinational reads, 1 synchronous write; x0 reads 0 and ignores writes.
REQ-020 Current fetched word is exposed as internal net named instruction = imem[PC[10:2]].
REQ-021 Supported instructions, standard RV encodings: ADD, SUB, AND, OR, SLL (shift amount rs2[5:0]), ADDI, LD, SD, BEQ, JAL, MUL (funct7 0000001, funct3 000, low 64 bits of the product).
REQ-022 Immediates are sign-extended to 64 bits; branch and JAL offsets are PC-relative byte offsets.
REQ-023 PC next = PC+4, or branch/jump target when BEQ condition holds or JAL executes; JAL writes PC+4 to rd.
REQ-024 LD: rd = dmem[(rs1+imm)[11:2]]; SD: dmem[(rs1+imm)[11:2]] = rs2 at the clock edge.
REQ-025 STOP: opcode 7'b1111110 halts the core; PC holds, no register or memory write; bits [31:7] are ignored by the core.
REQ-026 Unsupported opcodes execute as NOP (PC+4, no state change).
REQ-027 enable = 0: PC, registers and core-side memory writes are frozen; external ports remain fully functional.

Reset
REQ-028 arst_n low asynchronously forces PC = 0 and every reg_array entry = 0; memories are not cleared.
REQ-029 arst_n is released synchronously-safe; the first instruction executes on the first rising edge with enable = 1.
REQ-030 Reset asserted mid-program aborts execution immediately; all pending writes are discarded.

Verification
REQ-031 Load via external ports: enable = 0, write imem entries 0..511 and dmem entries 0..1023, read them back through ren_ext/ren_ext_2 -> data identical.
REQ-032 Basic program: ADDI x8=7; ADDI x9=9; SD x9 then LD x18; ADD x19=x8+x9; BEQ taken skipping a write; SLL x21=x9<<7 -> x8=7, x9=9, x18=9, x19=16, x20=25, x21=1152 at STOP.
REQ-033 MUL: x5=10, x6=19, MUL x9,x5,x6 -> x9 = 0xBE at STOP; repeat with destination x23 -> x23 = 0xBE.
REQ-034 x0 write: ADDI x0,x0,5 -> x0 still reads 0.
REQ-035 STOP: after STOP is fetched, PC and all registers are unchanged for 10 further cycles.
REQ-036 enable toggle: deassert enable for 5 cycles mid-program -> final register values unchanged, cycle count extended by 5.
